sp_ram_fifo_ctrl: RTL and testbench
===================================

// Module: sp_ram_fifo_ctrl
// PURPOSE
//  Valid/ready FIFO controller that drives one single-port block RAM (fpga_ram port set) as its storage.
//  It sits directly upstream of the RAM: it generates all enables and the address, and it issues the write data.
//  The RAM's 1-cycle registered read data is captured into a 2-entry output buffer, so the consumer sees a clean
//  valid/ready stream. Only one RAM access (read or write) may occur per cycle.
// PARAMETERS
//  DATA_WIDTH  16    payload width; passed unchanged, signedness irrelevant
//  MEM_SIZE    1024  RAM depth in entries; any value >=2, need not be a power of two
//  ADDR_WIDTH  (MEM_SIZE==1)?1:$clog2(MEM_SIZE)  RAM address width
//  LVL_WIDTH   $clog2(MEM_SIZE+3)  width of the occupancy output
// PORTS
//  clk             in   1           single clock, rising edge
//  rst_n           in   1           asynchronous active-low reset
//  in_valid        in   1           producer has data
//  in_ready        out  1           controller accepts data this cycle
//  in_data         in   DATA_WIDTH  write payload
//  out_valid       out  1           output buffer head valid
//  out_ready       in   1           consumer takes the head
//  out_data        out  DATA_WIDTH  head of the output buffer
//  level           out  LVL_WIDTH   ram_count + rd_inflight + ob_count
//  ram_enable_write out 1           equals wr_fire
//  ram_ctrl_write  out  1           equals wr_fire
//  ram_enable_read out  1           equals rd_fire
//  ram_addr        out  ADDR_WIDTH  wr_ptr when wr_fire, else rd_ptr
//  ram_data_write  out  DATA_WIDTH  in_data, passed through
//  ram_data_read   in   DATA_WIDTH  RAM read data, valid 1 cycle after rd_fire
// BEHAVIOUR
//  State registers: wr_ptr, rd_ptr (0..MEM_SIZE-1), ram_count (0..MEM_SIZE), rd_inflight (1b), ob_count (0..2), prio (1b).
//  Reset (async, rst_n=0): all of the above clear to 0, so out_valid=0, level=0, every RAM strobe=0; RAM contents are not cleared.
//  rd_want = (ram_count!=0) && (ob_count + rd_inflight < 2).
//  wr_want = in_valid && (ram_count < MEM_SIZE).
//  Arbitration: if exactly one of rd_want/wr_want is set, that one fires.
//  If both are set, prio=0 selects the read and prio=1 selects the write; prio toggles whenever both wanted in a cycle.
//  in_ready = (ram_count<MEM_SIZE) && !(rd_want && (!in_valid || prio==0)).
//  in_ready may depend on in_valid; out_valid never depends on out_ready.
//  wr_fire = in_valid && in_ready. rd_fire = rd_want && !wr_fire.
//  rd_fire and wr_fire are never both 1 in the same cycle.
//  Pointers increment on their fire, and wrap from MEM_SIZE-1 to 0.
//  ram_count: +1 on wr_fire, -1 on rd_fire.
//  rd_inflight <= rd_fire. When rd_inflight=1, ram_data_read is pushed into the output buffer at the end of that cycle.
//  Output buffer: 2-entry FIFO. out_valid = (ob_count!=0). Pop on out_valid && out_ready.
//  A push and a pop in the same cycle leave ob_count unchanged. Overflow is impossible by the rd_want rule.
//  Latency: a write accepted at edge 0 on an empty FIFO gives rd_fire in cycle 1 and ram_data_read in cycle 2.
//  out_valid=1 in cycle 3 (3 cycles from write to output).
//  Throughput: 1 word/cycle on one side. When both sides are active, writes and reads alternate, giving 0.5 word/cycle each.
//  Full: ram_count==MEM_SIZE forces in_ready=0. The total stored is MEM_SIZE+2 including the output buffer.
//  Empty: ram_count==0 forces no read. out_valid drops only when the buffer drains.
//  Reset mid-read: rd_inflight is cleared, so the stale ram_data_read is never captured.
//  Data order is strict FIFO; no bypass path around the RAM.
// STRUCTURE
//  Package sp_fifo_pkg:
//   - localparam OB_DEPTH=2
//   - function ptr_inc(ptr, size) for non-power-of-two wrap
//   - typedef enum {ARB_RD, ARB_WR} for the prio encoding
//  Sub-module out_skid_buf: 2-entry register FIFO, DATA_WIDTH parameter, push/pop/count, async active-low reset.
//  Top: pointers, counters, arbiter, and a fpga_ram instance in the testbench only (not inside this block).
// TESTING
//  1. Reset, then push 0x0011 once with out_ready=1 -> rd_fire in cycle 1; out_valid=1 with out_data=0x0011 in cycle 3; level back to 0 after the pop.
//  2. MEM_SIZE=4, out_ready=0, push 10 words:
//     -> after 6 accepted, in_ready=0 and level=6 (2 in the output buffer, 4 in RAM).
//     -> then drain and check the order 0..5.
//  3. MEM_SIZE=5 (non-power-of-two), 20 pushes and pops interleaved -> pointers wrap 4->0 and the data order is preserved.
//  4. in_valid=1 and out_ready=1 continuously with the FIFO half full -> rd_fire and wr_fire alternate each cycle, and neither side starves.
//  5. Assert rst_n=0 one cycle after rd_fire -> out_valid=0 and level=0 immediately; the next pushed word is the first output.
//  6. Random valid/ready for 10k cycles against a scoreboard -> no loss or duplication, rd_fire&wr_fire never both 1, level matches the model.

Source files
------------

// File: rtl/sp_fifo_pkg.sv
// Shared definitions for the single-port-RAM FIFO controller: output buffer
// depth, arbitration priority encoding and a pointer wrap helper.
package sp_fifo_pkg;

    localparam int OB_DEPTH = 2;

    typedef enum logic {
        ARB_RD = 1'b0,
        ARB_WR = 1'b1
    } arb_e;

    // Wraps at an arbitrary depth, so MEM_SIZE need not be a power of two.
    function automatic int ptr_inc(input int ptr, input int size);
        return (ptr == size - 1) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/sp_ram_fifo_ctrl_if.sv
// Producer and consumer valid/ready streams of the FIFO controller.
// The controller takes the slave view; the environment takes the master view.
interface sp_ram_fifo_ctrl_if #(
    parameter int DATA_WIDTH = 16
);
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_data;

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );
endinterface

// File: rtl/out_skid_buf.sv
// Two-entry register FIFO that catches the RAM read data; head_o is the
// oldest entry and is meaningful whenever count_o is non-zero.
module out_skid_buf #(
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push_i,
    input  logic [DATA_WIDTH-1:0] push_data_i,
    input  logic                  pop_i,
    output logic [DATA_WIDTH-1:0] head_o,
    output logic [1:0]            count_o
);
    logic [DATA_WIDTH-1:0] head_q, head_d;
    logic [DATA_WIDTH-1:0] tail_q, tail_d;
    logic [1:0]            count_q, count_d;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path leaves one unassigned and no latch is inferred.
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q + {1'b0, push_i} - {1'b0, pop_i};
        if (pop_i && count_q == 2'd2) begin
            head_d = tail_q;
        end
        if (push_i) begin
            if (count_q == 2'd0 || (count_q == 2'd1 && pop_i)) begin
                head_d = push_data_i;
            end else if (count_q == 2'd1 || pop_i) begin
                tail_d = push_data_i;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
        if (!rst_n) begin
            count_q <= 2'd0;
        end else begin
            count_q <= count_d;
        end
    end

    // NOTE: payload registers are deliberately not reset; count_q alone decides which of them hold data.
    always_ff @(posedge clk) begin
        head_q <= head_d;
        tail_q <= tail_d;
    end

    assign head_o  = head_q;
    assign count_o = count_q;
endmodule

// File: rtl/sp_ram_fifo_ctrl.sv
// Valid/ready FIFO controller using an external single-port RAM as storage,
// with a 2-entry output buffer absorbing the RAM's registered read latency.
module sp_ram_fifo_ctrl
    import sp_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int MEM_SIZE   = 1024,
    parameter int ADDR_WIDTH = (MEM_SIZE == 1) ? 1 : $clog2(MEM_SIZE),
    parameter int LVL_WIDTH  = $clog2(MEM_SIZE + 3)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    sp_ram_fifo_ctrl_if.slave     stream,
    output logic [LVL_WIDTH-1:0]  level,
    output logic                  ram_enable_write,
    output logic                  ram_ctrl_write,
    output logic                  ram_enable_read,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_data_write,
    input  logic [DATA_WIDTH-1:0] ram_data_read
);
    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_WIDTH-1:0]  ram_count_q, ram_count_d;
    logic                  rd_inflight_q;
    arb_e                  prio_q, prio_d;
    logic [1:0]            ob_count;
    logic [DATA_WIDTH-1:0] ob_head;
    logic                  ram_not_full, rd_want, wr_want, wr_fire, rd_fire, ob_pop;

    assign ram_not_full = ram_count_q < LVL_WIDTH'(MEM_SIZE);
    assign rd_want      = (ram_count_q != '0) &&
                          ((ob_count + 2'(rd_inflight_q)) < 2'(OB_DEPTH));
    assign wr_want      = stream.in_valid && ram_not_full;

    // A wanted read keeps in_ready low unless a valid write holds priority this cycle.
    assign stream.in_ready = ram_not_full && !(rd_want && (!stream.in_valid || prio_q == ARB_RD));
    assign wr_fire         = stream.in_valid && stream.in_ready;
    assign rd_fire         = rd_want && !wr_fire;

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        ram_count_d = ram_count_q;
        prio_d      = prio_q;
        if (wr_fire) begin
            wr_ptr_d    = ADDR_WIDTH'(ptr_inc(int'(wr_ptr_q), MEM_SIZE));
            ram_count_d = ram_count_q + 1'b1;
        end else if (rd_fire) begin
            rd_ptr_d    = ADDR_WIDTH'(ptr_inc(int'(rd_ptr_q), MEM_SIZE));
            ram_count_d = ram_count_q - 1'b1;
        end
        if (rd_want && wr_want) begin
            prio_d = (prio_q == ARB_RD) ? ARB_WR : ARB_RD;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            ram_count_q   <= '0;
            rd_inflight_q <= 1'b0;
            prio_q        <= ARB_RD;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            ram_count_q   <= ram_count_d;
            rd_inflight_q <= rd_fire;
            prio_q        <= prio_d;
        end
    end

    assign ob_pop = stream.out_valid && stream.out_ready;

    out_skid_buf #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_obuf (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (rd_inflight_q),
        .push_data_i (ram_data_read),
        .pop_i       (ob_pop),
        .head_o      (ob_head),
        .count_o     (ob_count)
    );

    assign stream.out_valid = (ob_count != 2'd0);
    assign stream.out_data  = ob_head;
    assign level            = ram_count_q + LVL_WIDTH'(rd_inflight_q) + LVL_WIDTH'(ob_count);
    assign ram_enable_write = wr_fire;
    assign ram_ctrl_write   = wr_fire;
    assign ram_enable_read  = rd_fire;
    assign ram_addr         = wr_fire ? wr_ptr_q : rd_ptr_q;
    assign ram_data_write   = stream.in_data;
endmodule

// File: tb/tb_sp_ram_fifo_ctrl.sv
// Directed and random bench for sp_ram_fifo_ctrl: one instance with a 4-deep
// RAM and one with a 5-deep RAM, selected by sel, each with its own RAM model.
module tb_sp_ram_fifo_ctrl;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        sel;
    logic        tb_in_valid, tb_out_ready;
    logic [15:0] tb_in_data;

    int          total = 0;
    int          bad   = 0;
    int          pops  = 0;
    logic [15:0] sb_q[$];
    int          wptr_m[2];
    int          rptr_m[2];
    bit          last_acc;

    always #5 clk = ~clk;

    sp_ram_fifo_ctrl_if #(.DATA_WIDTH(16)) if4 ();
    sp_ram_fifo_ctrl_if #(.DATA_WIDTH(16)) if5 ();

    logic [2:0]  lvl4, lvl5, addr5;
    logic [1:0]  addr4;
    logic        wen4, wctl4, ren4, wen5, wctl5, ren5;
    logic [15:0] wdata4, wdata5, rdata4, rdata5;
    logic [15:0] mem4 [0:3];
    logic [15:0] mem5 [0:4];

    assign if4.in_valid  = tb_in_valid && !sel;
    assign if4.in_data   = tb_in_data;
    assign if4.out_ready = tb_out_ready && !sel;
    assign if5.in_valid  = tb_in_valid && sel;
    assign if5.in_data   = tb_in_data;
    assign if5.out_ready = tb_out_ready && sel;

    sp_ram_fifo_ctrl #(.DATA_WIDTH(16), .MEM_SIZE(4)) u_dut4 (
        .clk              (clk),
        .rst_n            (rst_n),
        .stream           (if4),
        .level            (lvl4),
        .ram_enable_write (wen4),
        .ram_ctrl_write   (wctl4),
        .ram_enable_read  (ren4),
        .ram_addr         (addr4),
        .ram_data_write   (wdata4),
        .ram_data_read    (rdata4)
    );

    sp_ram_fifo_ctrl #(.DATA_WIDTH(16), .MEM_SIZE(5)) u_dut5 (
        .clk              (clk),
        .rst_n            (rst_n),
        .stream           (if5),
        .level            (lvl5),
        .ram_enable_write (wen5),
        .ram_ctrl_write   (wctl5),
        .ram_enable_read  (ren5),
        .ram_addr         (addr5),
        .ram_data_write   (wdata5),
        .ram_data_read    (rdata5)
    );

    // Read-first single-port RAM models with 1-cycle registered read data.
    always_ff @(posedge clk) begin
        if (wen4) mem4[addr4] <= wdata4;
        if (ren4) rdata4 <= mem4[addr4];
        if (wen5) mem5[addr5] <= wdata5;
        if (ren5) rdata5 <= mem5[addr5];
    end

    logic        ob_in_ready, ob_out_valid, ob_wen, ob_wctl, ob_ren;
    logic [15:0] ob_out_data, ob_wdata;
    logic [2:0]  ob_level, ob_addr;

    assign ob_in_ready  = sel ? if5.in_ready  : if4.in_ready;
    assign ob_out_valid = sel ? if5.out_valid : if4.out_valid;
    assign ob_out_data  = sel ? if5.out_data  : if4.out_data;
    assign ob_level     = sel ? lvl5 : lvl4;
    assign ob_wen       = sel ? wen5 : wen4;
    assign ob_wctl      = sel ? wctl5 : wctl4;
    assign ob_ren       = sel ? ren5 : ren4;
    assign ob_addr      = sel ? addr5 : {1'b0, addr4};
    assign ob_wdata     = sel ? wdata5 : wdata4;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    // Scoreboard bookkeeping at the sample point, then move to just after the next edge.
    task automatic advance();
        int ms;
        int s;
        ms       = sel ? 5 : 4;
        s        = sel ? 1 : 0;
        last_acc = 1'b0;
        check("level", 32'(ob_level), 32'(sb_q.size()));
        check("rw_excl", 32'(ob_wen && ob_ren), 32'd0);
        check("wr_strobe", 32'(ob_wen), 32'(tb_in_valid && ob_in_ready));
        if (ob_wen) begin
            check("wr_addr", 32'(ob_addr), 32'(wptr_m[s]));
            wptr_m[s] = (wptr_m[s] + 1) % ms;
        end
        if (ob_ren) begin
            check("rd_addr", 32'(ob_addr), 32'(rptr_m[s]));
            rptr_m[s] = (rptr_m[s] + 1) % ms;
        end
        if (tb_in_valid && ob_in_ready) begin
            sb_q.push_back(tb_in_data);
            last_acc = 1'b1;
        end
        if (ob_out_valid && tb_out_ready) begin
            check("pop_nonempty", 32'(sb_q.size() != 0), 32'd1);
            if (sb_q.size() != 0) check("data", 32'(ob_out_data), 32'(sb_q.pop_front()));
            pops++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string tag, input int bound);
        tb_in_valid  = 1'b0;
        tb_out_ready = 1'b1;
        for (int c = 0; c < bound && sb_q.size() != 0; c++) begin
            settle();
            advance();
        end
        settle();
        check({tag, "_level0"}, 32'(ob_level), 32'd0);
        check({tag, "_ov0"}, 32'(ob_out_valid), 32'd0);
        advance();
    endtask

    task automatic clear_model();
        sb_q.delete();
        wptr_m = '{0, 0};
        rptr_m = '{0, 0};
    endtask

    initial begin
        int          p0, n_acc;
        bit          got, prev_wen;

        rst_n        = 1'b0;
        sel          = 1'b1;
        tb_in_valid  = 1'b0;
        tb_out_ready = 1'b0;
        tb_in_data   = 16'h0000;
        clear_model();

        // Reset state
        repeat (2) @(posedge clk);
        settle();
        check("rst_ov", 32'(ob_out_valid), 32'd0);
        check("rst_level", 32'(ob_level), 32'd0);
        check("rst_strobes", {29'd0, ob_wen, ob_wctl, ob_ren}, 32'd0);
        check("rst_in_ready", 32'(ob_in_ready), 32'd1);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // 1: single word latency on the 5-deep instance
        tb_in_valid  = 1'b1;
        tb_in_data   = 16'h0011;
        tb_out_ready = 1'b1;
        settle();
        check("t1_in_ready", 32'(ob_in_ready), 32'd1);
        check("t1_ctrl_write", 32'(ob_wctl), 32'd1);
        check("t1_wr_addr0", 32'(ob_addr), 32'd0);
        check("t1_wdata", 32'(ob_wdata), 32'h0011);
        advance();
        tb_in_valid = 1'b0;
        settle();
        check("t1_rd_fire_c1", 32'(ob_ren), 32'd1);
        check("t1_ov_c1", 32'(ob_out_valid), 32'd0);
        advance();
        settle();
        check("t1_ov_c2", 32'(ob_out_valid), 32'd0);
        check("t1_level_c2", 32'(ob_level), 32'd1);
        advance();
        settle();
        check("t1_ov_c3", 32'(ob_out_valid), 32'd1);
        check("t1_data_c3", 32'(ob_out_data), 32'h0011);
        advance();
        settle();
        check("t1_level_after", 32'(ob_level), 32'd0);
        check("t1_ov_after", 32'(ob_out_valid), 32'd0);
        advance();

        // 2: fill the 4-deep instance with the consumer stalled
        sel          = 1'b0;
        tb_out_ready = 1'b0;
        tb_in_valid  = 1'b1;
        tb_in_data   = 16'h0000;
        n_acc        = 0;
        for (int c = 0; c < 10; c++) begin
            settle();
            advance();
            if (last_acc) begin
                n_acc++;
                tb_in_data = tb_in_data + 16'd1;
            end
        end
        settle();
        check("t2_accepted", 32'(n_acc), 32'd6);
        check("t2_in_ready", 32'(ob_in_ready), 32'd0);
        check("t2_level", 32'(ob_level), 32'd6);
        check("t2_ov", 32'(ob_out_valid), 32'd1);
        check("t2_head", 32'(ob_out_data), 32'h0000);
        advance();
        p0 = pops;
        drain("t2_drain", 40);
        check("t2_pops", 32'(pops - p0), 32'd6);

        // 3: interleaved traffic on the 5-deep instance, pointers wrap 4->0
        sel        = 1'b1;
        tb_in_data = 16'h0100;
        n_acc      = 0;
        p0         = pops;
        for (int c = 0; c < 200 && (n_acc < 20 || sb_q.size() != 0); c++) begin
            tb_in_valid  = (n_acc < 20);
            tb_out_ready = ((c % 3) != 1);
            settle();
            advance();
            if (last_acc) begin
                n_acc++;
                tb_in_data = tb_in_data + 16'd1;
            end
        end
        check("t3_pushed", 32'(n_acc), 32'd20);
        check("t3_popped", 32'(pops - p0), 32'd20);
        drain("t3_drain", 10);

        // 4: both sides busy from a partly filled state
        tb_out_ready = 1'b0;
        tb_in_valid  = 1'b1;
        tb_in_data   = 16'h0200;
        n_acc        = 0;
        for (int c = 0; c < 10 && n_acc < 3; c++) begin
            settle();
            advance();
            if (last_acc) begin
                n_acc++;
                tb_in_data = tb_in_data + 16'd1;
            end
        end
        tb_in_valid = 1'b0;
        repeat (4) begin
            settle();
            advance();
        end
        settle();
        check("t4_prefill_level", 32'(ob_level), 32'd3);
        advance();
        tb_in_valid  = 1'b1;
        tb_out_ready = 1'b1;
        n_acc        = 0;
        p0           = pops;
        prev_wen     = 1'b0;
        for (int c = 0; c < 16; c++) begin
            settle();
            if (c >= 3) check("t4_one_fire", 32'(ob_wen ^ ob_ren), 32'd1);
            if (c > 3)  check("t4_alternate", 32'(ob_wen), 32'(!prev_wen));
            prev_wen = ob_wen;
            advance();
            if (last_acc) begin
                n_acc++;
                tb_in_data = tb_in_data + 16'd1;
            end
        end
        check("t4_writes_progress", 32'(n_acc >= 6), 32'd1);
        check("t4_reads_progress", 32'(pops - p0 >= 6), 32'd1);
        drain("t4_drain", 20);

        // 5: reset while a read is in flight
        tb_out_ready = 1'b0;
        tb_in_valid  = 1'b1;
        tb_in_data   = 16'h0DEF;
        settle();
        advance();
        tb_in_valid = 1'b0;
        settle();
        check("t5_rd_fire", 32'(ob_ren), 32'd1);
        advance();
        settle();
        check("t5_level_pre", 32'(ob_level), 32'd1);
        rst_n = 1'b0;
        #1;
        check("t5_ov_rst", 32'(ob_out_valid), 32'd0);
        check("t5_level_rst", 32'(ob_level), 32'd0);
        check("t5_strobes_rst", {30'd0, ob_wen, ob_ren}, 32'd0);
        clear_model();
        @(posedge clk);
        #1;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        tb_in_valid  = 1'b1;
        tb_in_data   = 16'h0ABC;
        tb_out_ready = 1'b1;
        settle();
        advance();
        tb_in_valid = 1'b0;
        got         = 1'b0;
        for (int c = 0; c < 10 && !got; c++) begin
            settle();
            if (ob_out_valid) got = 1'b1;
            else advance();
        end
        check("t5_ov_seen", 32'(got), 32'd1);
        if (got) begin
            check("t5_first_word", 32'(ob_out_data), 32'h0ABC);
            advance();
        end
        drain("t5_drain", 10);

        // 6: random valid/ready against the scoreboard
        for (int c = 0; c < 10000; c++) begin
            tb_in_valid  = 1'($urandom_range(0, 1));
            tb_out_ready = 1'($urandom_range(0, 1));
            tb_in_data   = 16'($urandom);
            settle();
            advance();
        end
        drain("t6_drain", 40);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
